clock_period_monitor: RTL and testbench

Observer for a generated clock: samples an asynchronous monitored clock (the output of a clock generator BFM, gated or ungated) on a faster sampling clock. It measures the high and low phase times in sampling-clock ticks, counts rising edges and flags a stopped clock. It also provides a "wait N edges" handshake, the receive-side counterpart of a clock-advance request. It sits in the emulation-friendly testbench next to the clock generator and gives checkers and proxies a synthesizable view of what the generator actually produced.

---
 rtl/clock_period_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_clock_period_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_monitor.sv
// clock_period_monitor
//   Observes a generated clock (mon_clock) from a faster sampling clock.
//   Measures high/low phase durations in sampling cycles, counts rising
//   edges, flags a stopped clock and offers a "wait N rising edges"
//   handshake for testbench proxies.
//
// Ports
//   clock          sampling clock, all logic on its rising edge
//   reset          asynchronous active-high reset
//   mon_clock      monitored clock, asynchronous to clock
//   high_time      last captured high-phase duration (clock cycles)
//   low_time       last captured low-phase duration (clock cycles)
//   period_valid   both phase times come from the current uninterrupted run
//   period_changed one-cycle pulse when a valid-run capture differs from before
//   edge_count     free-running rising-edge count (wraps)
//   stalled        no edge seen for STALL_LIMIT cycles
//   wait_req       start a wait for wait_count rising edges (0 means 1)
//   wait_count     number of rising edges to wait for
//   wait_ready     wait FSM idle; request accepted when wait_req=1
//   wait_done      one-cycle pulse when the requested edges have elapsed
//   wait_abort     one-cycle pulse when an armed wait is killed by a stall
module clock_period_monitor #(
  parameter int CNT_WIDTH   = 16,
  parameter int EDGE_WIDTH  = 32,
  parameter int STALL_LIMIT = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mon_clock,
  output logic [CNT_WIDTH-1:0]  high_time,
  output logic [CNT_WIDTH-1:0]  low_time,
  output logic                  period_valid,
  output logic                  period_changed,
  output logic [EDGE_WIDTH-1:0] edge_count,
  output logic                  stalled,
  input  logic                  wait_req,
  input  logic [EDGE_WIDTH-1:0] wait_count,
  output logic                  wait_ready,
  output logic                  wait_done,
  output logic                  wait_abort
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  STALL_CNT = CNT_WIDTH'(STALL_LIMIT);
  localparam logic [EDGE_WIDTH-1:0] EDGE_ONE  = EDGE_WIDTH'(1);

  // ---------------------------------------------------------------------
  // Synchronizer and edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_dly;
  logic                   mon_s;
  logic                   rise;
  logic                   fall;
  logic                   any_edge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_pipe <= '0;
      sync_dly  <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], mon_clock};
      sync_dly  <= sync_pipe[SYNC_STAGES-1];
    end
  end

  assign mon_s    = sync_pipe[SYNC_STAGES-1];
  assign rise     =  mon_s & ~sync_dly;
  assign fall     = ~mon_s &  sync_dly;
  assign any_edge = rise | fall;

  // ---------------------------------------------------------------------
  // Phase measurement
  // ---------------------------------------------------------------------
  // phase_inc is the value captured at an edge: it counts the edge cycle
  // itself, so it equals the number of cycles since the previous edge.
  logic [CNT_WIDTH-1:0] phase_cnt;
  logic [CNT_WIDTH-1:0] phase_inc;
  logic                 seen_fall;
  logic                 stall_hit;

  assign phase_inc = (phase_cnt == CNT_MAX) ? CNT_MAX : phase_cnt + CNT_ONE;

  // Guarded by !stalled so a STALL_LIMIT equal to the saturation value
  // does not retrigger every cycle while the counter sits at all-ones.
  assign stall_hit = !any_edge && !stalled && (phase_inc == STALL_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_cnt      <= '0;
      high_time      <= '0;
      low_time       <= '0;
      period_valid   <= 1'b0;
      period_changed <= 1'b0;
      seen_fall      <= 1'b0;
      stalled        <= 1'b0;
      edge_count     <= '0;
    end else begin
      period_changed <= 1'b0;
      phase_cnt      <= any_edge ? '0 : phase_inc;

      if (stall_hit) begin
        stalled      <= 1'b1;
        period_valid <= 1'b0;
        seen_fall    <= 1'b0;
      end else if (any_edge) begin
        if (stalled) begin
          // First edge after a stall ends an incomplete phase: clear the
          // stall and throw this capture away.
          stalled <= 1'b0;
        end else if (fall) begin
          high_time <= phase_inc;
          seen_fall <= 1'b1;
          if (period_valid && (phase_inc != high_time))
            period_changed <= 1'b1;
        end else begin
          low_time <= phase_inc;
          // Registered period_valid is still 0 on the capture that sets it,
          // which keeps period_changed quiet on that first valid capture.
          if (seen_fall)
            period_valid <= 1'b1;
          if (period_valid && (phase_inc != low_time))
            period_changed <= 1'b1;
        end
      end

      if (rise)
        edge_count <= edge_count + EDGE_ONE;
    end
  end

  // ---------------------------------------------------------------------
  // Wait-for-N-edges handshake
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } wait_state_t;

  wait_state_t           state;
  logic [EDGE_WIDTH-1:0] wait_target;
  logic [EDGE_WIDTH-1:0] wait_seen;
  logic [EDGE_WIDTH-1:0] seen_inc;
  logic                  wait_kill;

  assign seen_inc  = wait_seen + EDGE_ONE;
  // A wait armed while the clock is already stopped is killed as well,
  // otherwise it could sit in ARMED forever.
  assign wait_kill = stall_hit || (stalled && !any_edge);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_target <= '0;
      wait_seen   <= '0;
      wait_ready  <= 1'b1;
      wait_done   <= 1'b0;
      wait_abort  <= 1'b0;
    end else begin
      wait_done  <= 1'b0;
      wait_abort <= 1'b0;
      case (state)
        IDLE: begin
          // A rise in the acceptance cycle is deliberately not counted.
          if (wait_req) begin
            wait_target <= (wait_count == '0) ? EDGE_ONE : wait_count;
            wait_seen   <= '0;
            wait_ready  <= 1'b0;
            state       <= ARMED;
          end
        end
        ARMED: begin
          if (rise) begin
            wait_seen <= seen_inc;
            if (seen_inc == wait_target) begin
              wait_done <= 1'b1;
              state     <= DONE;
            end
          end else if (wait_kill) begin
            wait_abort <= 1'b1;
            wait_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        DONE: begin
          wait_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          wait_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
module tb_clock_period_monitor;
  localparam int CW = 16;
  localparam int EW = 4;
  localparam int SL = 1024;
  localparam int SS = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          mon_clock;
  logic [CW-1:0] high_time, low_time;
  logic          period_valid, period_changed, stalled;
  logic [EW-1:0] edge_count;
  logic          wait_req;
  logic [EW-1:0] wait_count;
  logic          wait_ready, wait_done, wait_abort;

  clock_period_monitor #(.CNT_WIDTH(CW), .EDGE_WIDTH(EW), .STALL_LIMIT(SL), .SYNC_STAGES(SS)) dut (
    .clock(clock), .reset(reset), .mon_clock(mon_clock),
    .high_time(high_time), .low_time(low_time),
    .period_valid(period_valid), .period_changed(period_changed),
    .edge_count(edge_count), .stalled(stalled),
    .wait_req(wait_req), .wait_count(wait_count),
    .wait_ready(wait_ready), .wait_done(wait_done), .wait_abort(wait_abort)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pc_count = 0;
  int stall_rise_cyc = -1;

  // generator state
  int hi_len = 10, lo_len = 10, hi_cur = 10, lo_cur = 10, ph = 0;
  bit gate = 1'b1;
  int rises = 0;
  int last_tog = 0;
  int rise_cyc[$];

  typedef struct { int acc; int n; bit abort; } wexp_t;
  wexp_t sb[$];

  typedef struct { int hi; int lo; int eh; int el; int pulses; } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // monitored clock generator: toggles on negedges, phase lengths latched at each rise
  initial begin
    mon_clock = 1'b0;
    forever begin
      @(negedge clock);
      if (gate) begin
        mon_clock = 1'b0;
        ph = 0;
      end else begin
        ph++;
        if (ph >= (mon_clock ? hi_cur : lo_cur)) begin
          ph = 0;
          mon_clock = ~mon_clock;
          last_tog = cyc;
          if (mon_clock) begin
            rises++;
            rise_cyc.push_back(cyc);
            hi_cur = hi_len;
            lo_cur = lo_len;
          end
        end
      end
    end
  end

  // output monitor / scoreboard
  initial begin : mon
    bit done_prev, st_q;
    wexp_t e;
    int k, exp_c;
    done_prev = 0;
    st_q = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        done_prev = 0;
        st_q = 0;
        continue;
      end
      if (period_changed) pc_count++;
      if (stalled && !st_q) stall_rise_cyc = cyc;
      st_q = stalled;
      if (done_prev) begin
        chk("done_one_cycle", 64'(wait_done), 0);
        chk("ready_after_done", 64'(wait_ready), 1);
      end
      done_prev = wait_done;
      if (wait_done || wait_abort) begin
        if (sb.size() == 0) begin
          chk("spurious_done_abort", 64'({wait_done, wait_abort}), 0);
        end else begin
          e = sb.pop_front();
          chk("abort_flag", 64'(wait_abort), 64'(e.abort));
          chk("done_flag", 64'(wait_done), 64'(!e.abort));
          if (e.abort) begin
            chk("abort_cycle", 64'(cyc), 64'(last_tog + 3 + SL));
          end else begin
            k = 0;
            exp_c = -1;
            foreach (rise_cyc[i])
              if (rise_cyc[i] + 3 > e.acc) begin
                k++;
                if (k == e.n && exp_c < 0) exp_c = rise_cyc[i] + 3;
              end
            chk("wait_done_cycle", 64'(cyc), 64'(exp_c));
          end
        end
      end
    end
  end

  // waits for the next generated rise and then until it has been registered
  task automatic next_rise();
    int r0;
    int n;
    r0 = rises;
    n = 0;
    while (rises == r0 && n < 200) begin
      @(negedge clock); #1;
      n++;
    end
    if (rises == r0) chk("rise_timeout", 1, 0);
    repeat (3) @(negedge clock);
    #1;
  endtask

  task automatic do_wait(input int n, input bit expect_accept, input bit expect_abort);
    wexp_t e;
    @(negedge clock); #1;
    chk("wait_ready_before_req", 64'(wait_ready), 64'(expect_accept));
    wait_req = 1'b1;
    wait_count = EW'(n);
    if (expect_accept) begin
      e.acc = cyc + 1;
      e.n = (n == 0) ? 1 : n;
      e.abort = expect_abort;
      sb.push_back(e);
    end
    @(negedge clock); #1;
    wait_req = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clock); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 0);
  endtask

  task automatic gate_when_low();
    int n;
    n = 0;
    while (mon_clock !== 1'b0 && n < 100) begin
      @(negedge clock); #1;
      n++;
    end
    gate = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_high"}, 64'(high_time), 0);
    chk({tag, "_low"}, 64'(low_time), 0);
    chk({tag, "_valid"}, 64'(period_valid), 0);
    chk({tag, "_changed"}, 64'(period_changed), 0);
    chk({tag, "_edges"}, 64'(edge_count), 0);
    chk({tag, "_stalled"}, 64'(stalled), 0);
    chk({tag, "_ready"}, 64'(wait_ready), 1);
    chk({tag, "_done"}, 64'(wait_done), 0);
    chk({tag, "_abort"}, 64'(wait_abort), 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clock); #2;
    reset = 1'b1;
    gate = 1'b1;
    #1;
    check_reset_vals(tag);
    sb.delete();
    rise_cyc.delete();
    rises = 0;
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    gate = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{10, 10, 10, 10, 0};
    vt[1] = '{ 6,  6,  6,  6, 2};
    vt[2] = '{ 4,  9,  4,  9, 2};
    vt[3] = '{15,  5, 15,  5, 2};

    reset = 1'b1;
    wait_req = 1'b0;
    wait_count = '0;
    repeat (3) @(negedge clock);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    gate = 1'b0;

    // steady measurement vectors
    for (int i = 0; i < 4; i++) begin
      hi_len = vt[i].hi;
      lo_len = vt[i].lo;
      pc_count = 0;
      repeat (6) next_rise();
      chk($sformatf("v%0d_high", i), 64'(high_time), 64'(vt[i].eh));
      chk($sformatf("v%0d_low", i), 64'(low_time), 64'(vt[i].el));
      chk($sformatf("v%0d_valid", i), 64'(period_valid), 1);
      chk($sformatf("v%0d_pulses", i), 64'(pc_count), 64'(vt[i].pulses));
      chk($sformatf("v%0d_stalled", i), 64'(stalled), 0);
      chk($sformatf("v%0d_edges", i), 64'(edge_count), 64'(rises % 16));
    end

    // wait handshake on a 20-cycle period
    hi_len = 10;
    lo_len = 10;
    repeat (2) next_rise();
    repeat (5) @(negedge clock);
    do_wait(5, 1, 0);
    repeat (4) @(negedge clock);
    do_wait(3, 0, 0);
    drain(400);
    do_wait(0, 1, 0);
    drain(100);
    chk("edges_after_waits", 64'(edge_count), 64'(rises % 16));

    // stall with an armed wait
    repeat (5) @(negedge clock);
    do_wait(15, 1, 1);
    gate_when_low();
    stall_rise_cyc = -1;
    repeat (1100) @(negedge clock);
    #1;
    chk("stall_set", 64'(stalled), 1);
    chk("stall_valid_drop", 64'(period_valid), 0);
    chk("stall_cycle", 64'(stall_rise_cyc), 64'(last_tog + 3 + SL));
    chk("stall_abort_drained", 64'(sb.size()), 0);
    gate = 1'b0;
    next_rise();
    chk("restart_stall_clear", 64'(stalled), 0);
    chk("restart_not_valid", 64'(period_valid), 0);
    next_rise();
    chk("restart_valid", 64'(period_valid), 1);
    chk("restart_high", 64'(high_time), 10);
    chk("restart_low", 64'(low_time), 10);

    // asynchronous reset while ARMED
    do_wait(10, 1, 0);
    repeat (15) @(negedge clock);
    async_reset("rst_armed");
    repeat (2) next_rise();
    chk("post_rst_valid", 64'(period_valid), 1);
    chk("post_rst_edges", 64'(edge_count), 2);
    chk("post_rst_low", 64'(low_time), 10);

    // asynchronous reset during a long stopped phase
    gate_when_low();
    repeat (1100) @(negedge clock);
    #1;
    chk("sat_stalled", 64'(stalled), 1);
    async_reset("rst_stalled");
    repeat (2) next_rise();
    chk("post_rst2_valid", 64'(period_valid), 1);
    chk("post_rst2_high", 64'(high_time), 10);
    chk("post_rst2_edges", 64'(edge_count), 2);
    do_wait(2, 1, 0);
    drain(200);

    repeat (10) @(negedge clock);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
